// File: rtl/alu_wnd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_wnd_ctrl
// Brief    : Registered ALU opcode decode plus register-window select with a
//            call/return LIFO and a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_wnd_ctrl #(
    parameter int ALU_OP_W    = 4,
    parameter int NUM_WND     = 4,
    parameter int STACK_DEPTH = 4,
    localparam int WND_W      = $clog2(NUM_WND)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [7:0]          func,
    input  logic                err_clr,
    output logic                valid_out,
    output logic [ALU_OP_W-1:0] aluFunc,
    output logic                nop,
    output logic [WND_W-1:0]    window,
    output logic                ldWnd,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [ALU_OP_W-1:0] c_OP_MOVE = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] c_OP_ADD  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] c_OP_SUB  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] c_OP_AND  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] c_OP_OR   = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] c_OP_NOT  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] c_OP_NOP  = ALU_OP_W'(6);

    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic                r_valid;
    logic [ALU_OP_W-1:0] r_alu;
    logic                r_nop;
    logic [WND_W-1:0]    r_window;
    logic                r_ld;
    logic                r_err;
    logic [CNT_W-1:0]    r_count;
    logic [WND_W-1:0]    r_stack [STACK_DEPTH];

    logic                w_full;
    logic                w_empty;
    logic [4:0]          w_idx;
    logic                w_idx_ok;
    logic [PTR_W-1:0]    w_wr_ptr;
    logic [PTR_W-1:0]    w_rd_ptr;
    logic [ALU_OP_W-1:0] w_op;
    logic                w_err;
    logic                w_ld;
    logic                w_push;
    logic                w_pop;
    logic [WND_W-1:0]    w_wnd_next;

    assign w_full   = (r_count == c_CNT_FULL);
    assign w_empty  = (r_count == '0);
    assign w_idx    = func[4:0];
    assign w_idx_ok = ({1'b0, w_idx} < 6'(NUM_WND));
    // Pointers are only used when the count makes them in range.
    assign w_wr_ptr = PTR_W'(r_count);
    assign w_rd_ptr = PTR_W'(r_count - c_CNT_ONE);

    always_comb begin
        w_op       = c_OP_NOP;
        w_err      = 1'b0;
        w_ld       = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_wnd_next = r_window;
        if (valid_in) begin
            if (!func[7]) begin
                case (func)
                    8'h01:   w_op = c_OP_MOVE;
                    8'h02:   w_op = c_OP_ADD;
                    8'h04:   w_op = c_OP_SUB;
                    8'h08:   w_op = c_OP_AND;
                    8'h10:   w_op = c_OP_OR;
                    8'h20:   w_op = c_OP_NOT;
                    8'h40:   w_op = c_OP_NOP;
                    default: w_err = 1'b1;
                endcase
            end else begin
                case (func[6:5])
                    2'b00: begin
                        if (w_idx_ok) begin
                            w_ld       = 1'b1;
                            w_wnd_next = w_idx[WND_W-1:0];
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    2'b01: begin
                        if (w_idx_ok && !w_full) begin
                            w_ld       = 1'b1;
                            w_push     = 1'b1;
                            w_wnd_next = w_idx[WND_W-1:0];
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    2'b10: begin
                        if (!w_empty) begin
                            w_ld       = 1'b1;
                            w_pop      = 1'b1;
                            w_wnd_next = r_stack[w_rd_ptr];
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    default: w_err = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_alu    <= c_OP_NOP;
            r_nop    <= 1'b1;
            r_window <= '0;
            r_ld     <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= '0;
        end else begin
            r_valid <= valid_in;
            r_alu   <= w_op;
            r_nop   <= (w_op == c_OP_NOP);
            r_ld    <= w_ld;
            if (w_ld) begin
                r_window <= w_wnd_next;
            end
            if (w_push) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
            // A new error wins over a simultaneous clear.
            r_err <= w_err | (r_err & ~err_clr);
        end
    end

    // Stack storage needs no reset: the count alone defines valid entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_wr_ptr] <= r_window;
        end
    end

    assign valid_out   = r_valid;
    assign aluFunc     = r_alu;
    assign nop         = r_nop;
    assign window      = r_window;
    assign ldWnd       = r_ld;
    assign err         = r_err;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_wnd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_wnd_ctrl
// Brief    : Vector table with scoreboard queue for alu_wnd_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_wnd_ctrl;

    logic       clk;
    logic       rst;
    logic       valid_in;
    logic [7:0] func;
    logic       err_clr;
    logic       valid_out;
    logic [3:0] aluFunc;
    logic       nop;
    logic [1:0] window;
    logic       ldWnd;
    logic       stack_full;
    logic       stack_empty;
    logic       err;

    alu_wnd_ctrl #(
        .ALU_OP_W   (4),
        .NUM_WND    (4),
        .STACK_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .func       (func),
        .err_clr    (err_clr),
        .valid_out  (valid_out),
        .aluFunc    (aluFunc),
        .nop        (nop),
        .window     (window),
        .ldWnd      (ldWnd),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid_out, aluFunc, nop, window, ldWnd, err, stack_full, stack_empty}
    typedef struct {
        logic       vi;
        logic [7:0] f;
        logic       clr;
        logic [11:0] exp;
    } vec_t;

    vec_t        tbl [$];
    logic [11:0] sb  [$];
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic logic [11:0] pk(input logic vo, input logic [3:0] alu,
                                       input logic np, input logic [1:0] w,
                                       input logic ld, input logic e,
                                       input logic fu, input logic em);
        return {vo, alu, np, w, ld, e, fu, em};
    endfunction

    function automatic void add(input logic vi, input logic [7:0] f, input logic clr,
                                input logic [11:0] exp);
        vec_t v;
        v.vi  = vi;
        v.f   = f;
        v.clr = clr;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    function automatic logic [11:0] outs();
        return {valid_out, aluFunc, nop, window, ldWnd, err, stack_full, stack_empty};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got vo=%b alu=%0d nop=%b win=%0d ld=%b err=%b full=%b empty=%b, want vo=%b alu=%0d nop=%b win=%0d ld=%b err=%b full=%b empty=%b",
                      name, act[11], act[10:7], act[6], act[5:4], act[3], act[2], act[1], act[0],
                      exp[11], exp[10:7], exp[6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    task automatic step(input logic vi, input logic [7:0] f, input logic clr,
                        input logic [11:0] exp, input string name);
        @(negedge clk);
        valid_in = vi;
        func     = f;
        err_clr  = clr;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check(name, outs(), sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; valid_in = 1'b0; func = 8'h00; err_clr = 1'b0;

        add(1, 8'h02, 0, pk(1, 1, 0, 0, 0, 0, 0, 1));
        add(1, 8'h04, 0, pk(1, 2, 0, 0, 0, 0, 0, 1));
        add(1, 8'h40, 0, pk(1, 6, 1, 0, 0, 0, 0, 1));
        add(1, 8'h01, 0, pk(1, 0, 0, 0, 0, 0, 0, 1));
        add(1, 8'h08, 0, pk(1, 3, 0, 0, 0, 0, 0, 1));
        add(1, 8'h10, 0, pk(1, 4, 0, 0, 0, 0, 0, 1));
        add(1, 8'h20, 0, pk(1, 5, 0, 0, 0, 0, 0, 1));
        add(1, 8'h83, 0, pk(1, 6, 1, 3, 1, 0, 0, 1));
        add(1, 8'h85, 0, pk(1, 6, 1, 3, 0, 1, 0, 1));
        add(0, 8'h00, 1, pk(0, 6, 1, 3, 0, 0, 0, 1));
        add(1, 8'h80, 0, pk(1, 6, 1, 0, 1, 0, 0, 1));
        add(1, 8'hA1, 0, pk(1, 6, 1, 1, 1, 0, 0, 0));
        add(1, 8'hA2, 0, pk(1, 6, 1, 2, 1, 0, 0, 0));
        add(1, 8'hA3, 0, pk(1, 6, 1, 3, 1, 0, 0, 0));
        add(1, 8'hA0, 0, pk(1, 6, 1, 0, 1, 0, 1, 0));
        add(1, 8'hA1, 0, pk(1, 6, 1, 0, 0, 1, 1, 0));
        add(1, 8'hC0, 0, pk(1, 6, 1, 3, 1, 1, 0, 0));
        add(1, 8'hC0, 0, pk(1, 6, 1, 2, 1, 1, 0, 0));
        add(1, 8'hC0, 0, pk(1, 6, 1, 1, 1, 1, 0, 0));
        add(1, 8'hC0, 0, pk(1, 6, 1, 0, 1, 1, 0, 1));
        add(1, 8'hC0, 0, pk(1, 6, 1, 0, 0, 1, 0, 1));
        add(0, 8'h00, 1, pk(0, 6, 1, 0, 0, 0, 0, 1));
        add(1, 8'h03, 0, pk(1, 6, 1, 0, 0, 1, 0, 1));
        add(0, 8'h00, 1, pk(0, 6, 1, 0, 0, 0, 0, 1));
        add(1, 8'h00, 0, pk(1, 6, 1, 0, 0, 1, 0, 1));
        add(1, 8'hE0, 1, pk(1, 6, 1, 0, 0, 1, 0, 1));
        add(0, 8'h00, 1, pk(0, 6, 1, 0, 0, 0, 0, 1));
        add(0, 8'h81, 0, pk(0, 6, 1, 0, 0, 0, 0, 1));
        add(1, 8'h82, 0, pk(1, 6, 1, 2, 1, 0, 0, 1));
        add(1, 8'hA1, 0, pk(1, 6, 1, 1, 1, 0, 0, 0));
        add(1, 8'hC0, 0, pk(1, 6, 1, 2, 1, 0, 0, 1));
        add(1, 8'h82, 0, pk(1, 6, 1, 2, 1, 0, 0, 1));
        add(1, 8'hA4, 0, pk(1, 6, 1, 2, 0, 1, 0, 1));
        add(1, 8'h02, 1, pk(1, 1, 0, 2, 0, 0, 0, 1));
        add(1, 8'hA1, 0, pk(1, 6, 1, 1, 1, 0, 0, 0));
        add(1, 8'hA3, 0, pk(1, 6, 1, 3, 1, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), pk(0, 6, 1, 0, 0, 0, 0, 1));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vi, tbl[i].f, tbl[i].clr, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-cycle with two entries on the LIFO.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_now", outs(), pk(0, 6, 1, 0, 0, 0, 0, 1));
        @(negedge clk);
        valid_in = 1'b0;
        func     = 8'h00;
        err_clr  = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check("after_release", outs(), pk(0, 6, 1, 0, 0, 0, 0, 1));
        step(1, 8'hC0, 0, pk(1, 6, 1, 0, 0, 1, 0, 1), "ret_after_rst");
        step(0, 8'h00, 1, pk(0, 6, 1, 0, 0, 0, 0, 1), "final_clr");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
